// File: rtl/dm_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dm_arb_pkg
// Purpose  : Shared size codes, FSM states and owner ids for the DM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package dm_arb_pkg;
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b11;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    typedef enum logic [0:0] {
        OWN_CPU = 1'b0,
        OWN_EXT = 1'b1
    } owner_t;
endpackage
`default_nettype wire

// File: rtl/dm_req_check.sv
`default_nettype none
// ============================================================================
// Module   : dm_req_check
// Purpose  : Flags illegal size, misalignment or out-of-range access.
// Revision : 1.0 - initial release
// ============================================================================
module dm_req_check
    import dm_arb_pkg::*;
#(
    parameter int DM_BYTES = 2048
) (
    input  logic [31:0] addr,
    input  logic [1:0]  sbhw,
    output logic        err
);
    logic [32:0] w_size;
    logic [32:0] w_last;
    logic        w_misalign;
    logic        w_bad_size;

    // Last byte computed at 33 bits so addresses near 2^32 cannot wrap into range
    always_comb begin
        w_size     = 33'd1;
        w_misalign = 1'b0;
        w_bad_size = 1'b0;
        case (sbhw)
            SZ_B: w_size = 33'd1;
            SZ_H: begin
                w_size     = 33'd2;
                w_misalign = addr[0];
            end
            SZ_W: begin
                w_size     = 33'd4;
                w_misalign = |addr[1:0];
            end
            default: w_bad_size = 1'b1;
        endcase
        w_last = {1'b0, addr} + w_size - 33'd1;
        err    = w_bad_size | w_misalign | (w_last >= 33'(DM_BYTES));
    end
endmodule
`default_nettype wire

// File: rtl/dm_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dm_port_arbiter
// Purpose  : Two-port data-memory arbiter, CPU priority with EXT starvation guard.
// Revision : 1.0 - initial release
// ============================================================================
module dm_port_arbiter
    import dm_arb_pkg::*;
#(
    parameter int DM_BYTES     = 2048,
    parameter int MAX_CPU_WINS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [1:0]  cpu_sbhw,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_ack,
    output logic        cpu_err,
    output logic [31:0] cpu_rdata,
    input  logic        ext_req,
    input  logic        ext_we,
    input  logic [1:0]  ext_sbhw,
    input  logic [31:0] ext_addr,
    input  logic [31:0] ext_wdata,
    output logic        ext_ack,
    output logic        ext_err,
    output logic [31:0] ext_rdata,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic        dm_we,
    output logic        dm_re,
    output logic [1:0]  dm_sbhw,
    input  logic [31:0] dm_rdata
);
    localparam int c_WIN_W = $clog2(MAX_CPU_WINS + 1);

    arb_state_t         r_state;
    arb_state_t         w_state_nxt;
    logic [c_WIN_W-1:0] r_win_cnt;
    owner_t             r_owner;
    logic               r_we;
    logic [1:0]         r_sbhw;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic               w_err;
    logic               w_pick_ext;
    logic               w_contended;
    logic [31:0]        w_load;

    dm_req_check #(.DM_BYTES(DM_BYTES)) u_check (
        .addr (r_addr),
        .sbhw (r_sbhw),
        .err  (w_err)
    );

    assign w_contended = cpu_req & ext_req;
    assign w_pick_ext  = ext_req & (~cpu_req | (r_win_cnt == c_WIN_W'(MAX_CPU_WINS)));

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Write enable is gated by rst so a reset landing in GRANT never commits a store
    always_comb begin
        w_state_nxt = r_state;
        dm_addr     = 32'd0;
        dm_wdata    = 32'd0;
        dm_sbhw     = 2'b00;
        dm_we       = 1'b0;
        dm_re       = 1'b0;
        case (r_state)
            IDLE: begin
                if (cpu_req | ext_req) w_state_nxt = GRANT;
            end
            GRANT: begin
                w_state_nxt = IDLE;
                dm_addr     = r_addr;
                dm_wdata    = r_wdata;
                dm_sbhw     = r_sbhw;
                dm_we       = r_we & ~rst & ~w_err;
                dm_re       = ~r_we & ~w_err;
            end
        endcase
    end

    always_comb begin
        case (r_sbhw)
            SZ_B:    w_load = {24'd0, dm_rdata[7:0]};
            SZ_H:    w_load = {16'd0, dm_rdata[15:0]};
            default: w_load = dm_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_win_cnt <= '0;
            r_owner   <= OWN_CPU;
            r_we      <= 1'b0;
            r_sbhw    <= 2'b00;
            r_addr    <= 32'd0;
            r_wdata   <= 32'd0;
            cpu_ack   <= 1'b0;
            cpu_err   <= 1'b0;
            cpu_rdata <= 32'd0;
            ext_ack   <= 1'b0;
            ext_err   <= 1'b0;
            ext_rdata <= 32'd0;
        end else begin
            cpu_ack <= 1'b0;
            cpu_err <= 1'b0;
            ext_ack <= 1'b0;
            ext_err <= 1'b0;
            if (!ext_req) r_win_cnt <= '0;

            if (r_state == IDLE && (cpu_req | ext_req)) begin
                if (w_pick_ext) begin
                    r_owner   <= OWN_EXT;
                    r_we      <= ext_we;
                    r_sbhw    <= ext_sbhw;
                    r_addr    <= ext_addr;
                    r_wdata   <= ext_wdata;
                    r_win_cnt <= '0;
                end else begin
                    r_owner <= OWN_CPU;
                    r_we    <= cpu_we;
                    r_sbhw  <= cpu_sbhw;
                    r_addr  <= cpu_addr;
                    r_wdata <= cpu_wdata;
                    // Guard in w_pick_ext keeps this below MAX_CPU_WINS + 1
                    if (w_contended) r_win_cnt <= r_win_cnt + c_WIN_W'(1);
                end
            end

            if (r_state == GRANT) begin
                if (r_owner == OWN_CPU) begin
                    cpu_ack <= 1'b1;
                    cpu_err <= w_err;
                    if (w_err)      cpu_rdata <= 32'd0;
                    else if (!r_we) cpu_rdata <= w_load;
                end else begin
                    ext_ack <= 1'b1;
                    ext_err <= w_err;
                    if (w_err)      ext_rdata <= 32'd0;
                    else if (!r_we) ext_rdata <= w_load;
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_dm_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_port_arbiter
// Purpose  : Self-checking bench with a transaction-level model and byte memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dm_port_arbiter;
    localparam int DM_BYTES     = 2048;
    localparam int MAX_CPU_WINS = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0, ext_req = 1'b0, ext_we = 1'b0;
    logic [1:0]  cpu_sbhw = 2'b00, ext_sbhw = 2'b00;
    logic [31:0] cpu_addr = 32'd0, cpu_wdata = 32'd0, ext_addr = 32'd0, ext_wdata = 32'd0;
    logic        cpu_ack, cpu_err, ext_ack, ext_err;
    logic [31:0] cpu_rdata, ext_rdata;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        dm_we, dm_re;
    logic [1:0]  dm_sbhw;

    dm_port_arbiter #(.DM_BYTES(DM_BYTES), .MAX_CPU_WINS(MAX_CPU_WINS)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_sbhw(cpu_sbhw), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
        .ext_req(ext_req), .ext_we(ext_we), .ext_sbhw(ext_sbhw), .ext_addr(ext_addr),
        .ext_wdata(ext_wdata), .ext_ack(ext_ack), .ext_err(ext_err), .ext_rdata(ext_rdata),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we), .dm_re(dm_re),
        .dm_sbhw(dm_sbhw), .dm_rdata(dm_rdata)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Memory attached to the DUT: combinational little-endian read, write on dm_we
    logic [7:0] mem [DM_BYTES] = '{default: 8'h00};

    always_comb begin
        dm_rdata = 32'd0;
        for (int i = 0; i < 4; i++) begin
            if (longint'(dm_addr) + i < DM_BYTES)
                dm_rdata[8*i +: 8] = mem[int'(dm_addr) + i];
        end
    end

    always @(posedge clk) begin
        if (dm_we) begin
            for (int i = 0; i < 4; i++) begin
                if (i < size_of(dm_sbhw) && longint'(dm_addr) + i < DM_BYTES)
                    mem[int'(dm_addr) + i] <= dm_wdata[8*i +: 8];
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic int size_of(input logic [1:0] sz);
        case (sz)
            2'b00:   return 1;
            2'b01:   return 2;
            2'b11:   return 4;
            default: return 0;
        endcase
    endfunction

    function automatic bit legal(input logic [1:0] sz, input logic [31:0] a);
        longint la = longint'(a);
        int     s  = size_of(sz);
        if (s == 0) return 1'b0;
        return ((la % s) == 0) && (la + s <= DM_BYTES);
    endfunction

    logic [7:0]  ref_mem [DM_BYTES] = '{default: 8'h00};
    bit          g_active = 1'b0, g_ext = 1'b0, g_we = 1'b0, g_legal = 1'b0;
    logic [1:0]  g_sbhw = 2'b00;
    logic [31:0] g_addr = 32'd0, g_wdata = 32'd0;
    int          streak = 0;
    bit          m_cpu_ack = 1'b0, m_cpu_err = 1'b0, m_ext_ack = 1'b0, m_ext_err = 1'b0;
    logic [31:0] m_cpu_rdata = 32'd0, m_ext_rdata = 32'd0;
    bit          grants [$];

    task automatic model_step();
        logic [31:0] d;
        int          s;
        m_cpu_ack = 1'b0; m_cpu_err = 1'b0; m_ext_ack = 1'b0; m_ext_err = 1'b0;
        if (rst) begin
            g_active = 1'b0; streak = 0; m_cpu_rdata = 32'd0; m_ext_rdata = 32'd0;
            return;
        end
        if (!ext_req) streak = 0;
        if (g_active) begin
            g_active = 1'b0;
            d = 32'd0;
            s = size_of(g_sbhw);
            if (g_legal) begin
                for (int i = 0; i < s; i++) begin
                    if (g_we) ref_mem[int'(g_addr) + i] = g_wdata[8*i +: 8];
                    else      d[8*i +: 8] = ref_mem[int'(g_addr) + i];
                end
            end
            if (g_ext) begin
                m_ext_ack = 1'b1; m_ext_err = !g_legal;
                if (!g_legal) m_ext_rdata = 32'd0; else if (!g_we) m_ext_rdata = d;
            end else begin
                m_cpu_ack = 1'b1; m_cpu_err = !g_legal;
                if (!g_legal) m_cpu_rdata = 32'd0; else if (!g_we) m_cpu_rdata = d;
            end
        end else if (cpu_req || ext_req) begin
            g_ext = ext_req && (!cpu_req || streak == MAX_CPU_WINS);
            if (g_ext) streak = 0;
            else if (ext_req) streak++;
            if (g_ext) begin
                g_we = ext_we; g_sbhw = ext_sbhw; g_addr = ext_addr; g_wdata = ext_wdata;
            end else begin
                g_we = cpu_we; g_sbhw = cpu_sbhw; g_addr = cpu_addr; g_wdata = cpu_wdata;
            end
            g_legal  = legal(g_sbhw, g_addr);
            g_active = 1'b1;
            grants.push_back(g_ext);
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle compare of every DUT output against the model
    initial forever begin
        @(posedge clk);
        #2;
        chk("cpu_ack",   {31'd0, cpu_ack}, {31'd0, m_cpu_ack});
        chk("cpu_err",   {31'd0, cpu_err}, {31'd0, m_cpu_err});
        chk("cpu_rdata", cpu_rdata, m_cpu_rdata);
        chk("ext_ack",   {31'd0, ext_ack}, {31'd0, m_ext_ack});
        chk("ext_err",   {31'd0, ext_err}, {31'd0, m_ext_err});
        chk("ext_rdata", ext_rdata, m_ext_rdata);
        chk("dm_we",     {31'd0, dm_we}, {31'd0, g_active && g_legal && g_we && !rst});
        chk("dm_re",     {31'd0, dm_re}, {31'd0, g_active && g_legal && !g_we});
        chk("dm_addr",   dm_addr,  g_active ? g_addr  : 32'd0);
        chk("dm_wdata",  dm_wdata, g_active ? g_wdata : 32'd0);
        chk("dm_sbhw",   {30'd0, dm_sbhw}, {30'd0, (g_active ? g_sbhw : 2'b00)});
    end

    // ---------------- directed stimulus ----------------
    task automatic access(input bit ext, input bit we, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er);
        int  n;
        bit  got;
        @(negedge clk);
        if (ext) begin
            ext_req = 1'b1; ext_we = we; ext_sbhw = sz; ext_addr = a; ext_wdata = wd;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_sbhw = sz; cpu_addr = a; cpu_wdata = wd;
        end
        n = 0; got = 1'b0;
        while (!got && n < 8) begin
            @(posedge clk); #1;
            n++;
            got = ext ? ext_ack : cpu_ack;
        end
        if (ext) ext_req = 1'b0; else cpu_req = 1'b0;
        chk("latency", n, 2);
        rd = ext ? ext_rdata : cpu_rdata;
        er = ext ? ext_err : cpu_err;
    endtask

    logic [31:0] rd;
    logic        er;
    bit          exp_order [13] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0};

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_cpu_rdata", cpu_rdata, 32'd0);
        chk("rst_ext_ack", {31'd0, ext_ack}, 32'd0);
        rst = 1'b0;

        access(1'b0, 1'b1, 2'b11, 32'h10, 32'hDEADBEEF, rd, er);
        chk("cpu_sw_err", {31'd0, er}, 32'd0);
        access(1'b0, 1'b0, 2'b11, 32'h10, 32'h0, rd, er);
        chk("cpu_lw_rdata", rd, 32'hDEADBEEF);
        chk("cpu_lw_err", {31'd0, er}, 32'd0);

        access(1'b1, 1'b1, 2'b00, 32'h7FF, 32'h000000A5, rd, er);
        access(1'b1, 1'b0, 2'b00, 32'h7FF, 32'h0, rd, er);
        chk("ext_lb_rdata", rd, 32'h000000A5);
        access(1'b1, 1'b1, 2'b01, 32'h7FF, 32'h0000BEEF, rd, er);
        chk("ext_sh_edge_err", {31'd0, er}, 32'd1);
        chk("ext_sh_edge_rdata", rd, 32'd0);

        access(1'b0, 1'b0, 2'b11, 32'h12, 32'h0, rd, er);
        chk("misalign_err", {31'd0, er}, 32'd1);
        chk("misalign_rdata", rd, 32'd0);
        access(1'b0, 1'b0, 2'b10, 32'h0, 32'h0, rd, er);
        chk("badsize_err", {31'd0, er}, 32'd1);
        chk("badsize_rdata", rd, 32'd0);
        access(1'b1, 1'b0, 2'b11, 32'hFFFF_FFFC, 32'h0, rd, er);
        chk("wrap_err", {31'd0, er}, 32'd1);

        // Contention: both held 20 cycles, then EXT drops and CPU keeps winning
        repeat (2) @(negedge clk);
        grants.delete();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_sbhw = 2'b11; cpu_addr = 32'h10;
        ext_req = 1'b1; ext_we = 1'b0; ext_sbhw = 2'b00; ext_addr = 32'h7FF;
        repeat (20) @(negedge clk);
        ext_req = 1'b0;
        repeat (6) @(negedge clk);
        cpu_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("grant_count", grants.size(), 13);
        for (int i = 0; i < 13 && i < grants.size(); i++)
            chk($sformatf("grant_order[%0d]", i), {31'd0, grants[i]}, {31'd0, exp_order[i]});

        // Reset landing in the GRANT cycle of a store
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_sbhw = 2'b11; cpu_addr = 32'h20; cpu_wdata = 32'h11223344;
        @(negedge clk);
        rst = 1'b1; cpu_req = 1'b0;
        @(posedge clk); #1;
        chk("rst_grant_no_ack", {31'd0, cpu_ack}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_grant_mem", {mem[35], mem[34], mem[33], mem[32]}, 32'd0);

        // Request held through its ack yields a second access two cycles later
        begin
            int  n1, n2;
            @(negedge clk);
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_sbhw = 2'b11; cpu_addr = 32'h10;
            n1 = 0;
            do begin @(posedge clk); #1; n1++; end while (!cpu_ack && n1 < 8);
            chk("held_first_latency", n1, 2);
            n2 = 0;
            do begin @(posedge clk); #1; n2++; end while (!cpu_ack && n2 < 8);
            cpu_req = 1'b0;
            chk("held_second_gap", n2, 2);
            chk("held_rdata", cpu_rdata, 32'hDEADBEEF);
        end

        repeat (3) @(negedge clk);
        begin
            int bad = 0;
            for (int i = 0; i < DM_BYTES; i++) if (mem[i] !== ref_mem[i]) bad++;
            chk("mem_image", bad, 0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
